// File: rtl/sys_mem_warb_if.sv
// Controller-side command and read-return bus of sys_mem_warb.
interface sys_mem_warb_if #(
  parameter int MEM_DATA_W = 32,
  parameter int MEM_ADDR_W = 27
);
  logic                  cntrlr_wait;
  logic                  cntrlr_wren;
  logic                  cntrlr_rden;
  logic [MEM_ADDR_W-1:0] cntrlr_addr;
  logic [MEM_DATA_W-1:0] cntrlr_wdata;
  logic                  cntrlr_rd_valid;
  logic [MEM_DATA_W-1:0] cntrlr_rdata;

  modport master (
    input  cntrlr_wait, cntrlr_rd_valid, cntrlr_rdata,
    output cntrlr_wren, cntrlr_rden, cntrlr_addr, cntrlr_wdata
  );
  modport slave (
    output cntrlr_wait, cntrlr_rd_valid, cntrlr_rdata,
    input  cntrlr_wren, cntrlr_rden, cntrlr_addr, cntrlr_wdata
  );
endinterface

// File: rtl/sys_mem_warb.sv
// N-agent weighted round-robin arbiter in front of one sys_mem controller port.
// Define SYS_MEM_WARB_PERF_CNTR_EN to add grant counters (0x30+i) and a stall counter (0x08).
module sys_mem_warb #(
  parameter int                   LB_DATA_W        = 32,
  parameter int                   LB_ADDR_W        = 8,
  parameter int                   MEM_DATA_W       = 32,
  parameter int                   MEM_ADDR_W       = 27,
  parameter int                   NUM_AGENTS       = 4,
  parameter int                   WEIGHT_W         = 4,
  parameter int                   DEFAULT_WEIGHT   = 1,
  parameter int                   RD_TAG_DEPTH     = 16,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe,
  parameter int                   AGENT_ID_W       = $clog2(NUM_AGENTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lb_wr_en,
  input  logic                         lb_rd_en,
  input  logic [LB_ADDR_W-1:0]         lb_addr,
  input  logic [LB_DATA_W-1:0]         lb_wr_data,
  output logic                         lb_wr_valid,
  output logic                         lb_rd_valid,
  output logic [LB_DATA_W-1:0]         lb_rd_data,
  input  logic [NUM_AGENTS-1:0]        agent_wren,
  input  logic [NUM_AGENTS-1:0]        agent_rden,
  input  logic [NUM_AGENTS*MEM_ADDR_W-1:0] agent_addr,
  input  logic [NUM_AGENTS*MEM_DATA_W-1:0] agent_wdata,
  output logic [NUM_AGENTS-1:0]        agent_wait,
  output logic [NUM_AGENTS-1:0]        agent_rd_valid,
  output logic [NUM_AGENTS*MEM_DATA_W-1:0] agent_rdata,
  sys_mem_warb_if.master               cntrlr
);
  localparam int TAG_PTR_W = $clog2(RD_TAG_DEPTH);
  localparam int TAG_CNT_W = TAG_PTR_W + 1;
  localparam logic [TAG_CNT_W-1:0] TAG_FULL = TAG_CNT_W'(RD_TAG_DEPTH);

  logic                  arb_en_q, arb_en_d;
  logic [WEIGHT_W-1:0]   weight_q [NUM_AGENTS];
  logic [WEIGHT_W-1:0]   weight_d [NUM_AGENTS];
  logic [WEIGHT_W-1:0]   credit_q [NUM_AGENTS];
  logic [WEIGHT_W-1:0]   credit_d [NUM_AGENTS];
  logic [MEM_ADDR_W-1:0] offset_q [NUM_AGENTS];
  logic [MEM_ADDR_W-1:0] offset_d [NUM_AGENTS];
  logic [AGENT_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic                  out_vld_q, out_vld_d, out_wr_q, out_wr_d;
  logic [MEM_ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [MEM_DATA_W-1:0] out_wdata_q, out_wdata_d;
  logic [AGENT_ID_W-1:0] out_id_q, out_id_d;
  logic [AGENT_ID_W-1:0] tag_mem_q [RD_TAG_DEPTH];
  logic [AGENT_ID_W-1:0] tag_mem_d [RD_TAG_DEPTH];
  logic [TAG_PTR_W-1:0]  tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
  logic [TAG_CNT_W-1:0]  tag_cnt_q, tag_cnt_d;
  logic [NUM_AGENTS-1:0] rd_vld_q, rd_vld_d;
  logic [MEM_DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]            flags_q, flags_d;
  logic                  lb_wr_vld_q, lb_rd_vld_q;
  logic [LB_DATA_W-1:0]  lb_rd_data_q, lb_rd_data_d;

  logic [MEM_ADDR_W-1:0] a_addr  [NUM_AGENTS];
  logic [MEM_DATA_W-1:0] a_wdata [NUM_AGENTS];
  logic [NUM_AGENTS-1:0] req, elig, has_credit, gnt;
  logic [AGENT_ID_W-1:0] gnt_id;
  logic                  found, accept, reload, out_ready, tag_full;
  logic                  push, pop, push_ok;
  logic                  unused_lb_bits;

`ifdef SYS_MEM_WARB_PERF_CNTR_EN
  logic [31:0] gcnt_q [NUM_AGENTS];
  logic [31:0] gcnt_d [NUM_AGENTS];
  logic [31:0] stall_q, stall_d;
`endif

  assign unused_lb_bits = ^lb_wr_data;

  always_comb begin
    for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
      a_addr[i]  = agent_addr[i*MEM_ADDR_W +: MEM_ADDR_W];
      a_wdata[i] = agent_wdata[i*MEM_DATA_W +: MEM_DATA_W];
    end
  end

  // Arbitration: scan upward from rr_ptr+1; read eligibility counts the read still in the stage.
  always_comb begin
    req        = agent_wren | agent_rden;
    out_ready  = ~out_vld_q | ~cntrlr.cntrlr_wait;
    tag_full   = (tag_cnt_q + TAG_CNT_W'(out_vld_q & ~out_wr_q)) >= TAG_FULL;
    has_credit = '0;
    for (int unsigned i = 0; i < NUM_AGENTS; i++) has_credit[i] = credit_q[i] != '0;
    elig   = req & has_credit & {NUM_AGENTS{arb_en_q}} & (agent_wren | {NUM_AGENTS{~tag_full}});
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_AGENTS; k++) begin
      if (!found && elig[(32'(rr_ptr_q) + k) % NUM_AGENTS]) begin
        found  = 1'b1;
        gnt_id = AGENT_ID_W'((32'(rr_ptr_q) + k) % NUM_AGENTS);
        gnt[(32'(rr_ptr_q) + k) % NUM_AGENTS] = 1'b1;
      end
    end
    accept     = found & out_ready;
    reload     = (|req) & ~(|(req & has_credit));
    agent_wait = req & ~(gnt & {NUM_AGENTS{out_ready}});
  end

  always_comb begin
    arb_en_d    = arb_en_q;
    weight_d    = weight_q;
    offset_d    = offset_q;
    credit_d    = credit_q;
    rr_ptr_d    = rr_ptr_q;
    out_vld_d   = out_vld_q;
    out_wr_d    = out_wr_q;
    out_addr_d  = out_addr_q;
    out_wdata_d = out_wdata_q;
    out_id_d    = out_id_q;
    tag_mem_d   = tag_mem_q;
    tag_wptr_d  = tag_wptr_q;
    tag_rptr_d  = tag_rptr_q;
    rd_vld_d    = '0;
    rdata_d     = rdata_q;

    if (reload) credit_d = weight_q;
    else if (accept) credit_d[gnt_id] = credit_q[gnt_id] - WEIGHT_W'(1);

    if (out_ready) begin
      out_vld_d = accept;
      if (accept) begin
        out_wr_d    = agent_wren[gnt_id];
        out_addr_d  = a_addr[gnt_id] + offset_q[gnt_id];
        out_wdata_d = a_wdata[gnt_id];
        out_id_d    = gnt_id;
        rr_ptr_d    = gnt_id;
      end
    end

    // A pop in the same cycle frees the slot, so push-while-full is only dropped without one.
    push    = out_vld_q & ~out_wr_q & ~cntrlr.cntrlr_wait;
    pop     = cntrlr.cntrlr_rd_valid & (tag_cnt_q != '0);
    push_ok = push & ((tag_cnt_q != TAG_FULL) | pop);
    if (push_ok) begin
      tag_mem_d[tag_wptr_q] = out_id_q;
      tag_wptr_d = tag_wptr_q + TAG_PTR_W'(1);
    end
    if (pop) begin
      rd_vld_d[tag_mem_q[tag_rptr_q]] = 1'b1;
      rdata_d    = cntrlr.cntrlr_rdata;
      tag_rptr_d = tag_rptr_q + TAG_PTR_W'(1);
    end
    tag_cnt_d = tag_cnt_q + TAG_CNT_W'(push_ok) - TAG_CNT_W'(pop);

    flags_d = (lb_rd_en && lb_addr == '0) ? 3'b000 : flags_q;
    flags_d = flags_d | {|(agent_wren & agent_rden), push & ~push_ok,
                         cntrlr.cntrlr_rd_valid & (tag_cnt_q == '0)};

    if (lb_wr_en) begin
      if (lb_addr == LB_ADDR_W'(1)) arb_en_d = lb_wr_data[0];
      for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
        if (lb_addr == LB_ADDR_W'(32'h10 + i)) weight_d[i] = WEIGHT_W'(lb_wr_data);
        if (lb_addr == LB_ADDR_W'(32'h20 + i)) offset_d[i] = MEM_ADDR_W'(lb_wr_data);
      end
    end

    lb_rd_data_d = lb_rd_data_q;
    if (lb_rd_en) begin
      lb_rd_data_d = DEFAULT_DATA_VAL;
      if (lb_addr == '0) lb_rd_data_d = LB_DATA_W'(flags_q);
      if (lb_addr == LB_ADDR_W'(1)) lb_rd_data_d = LB_DATA_W'(arb_en_q);
      for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
        if (lb_addr == LB_ADDR_W'(32'h10 + i)) lb_rd_data_d = LB_DATA_W'(weight_q[i]);
        if (lb_addr == LB_ADDR_W'(32'h20 + i)) lb_rd_data_d = LB_DATA_W'(offset_q[i]);
`ifdef SYS_MEM_WARB_PERF_CNTR_EN
        if (lb_addr == LB_ADDR_W'(32'h30 + i)) lb_rd_data_d = LB_DATA_W'(gcnt_q[i]);
`endif
      end
`ifdef SYS_MEM_WARB_PERF_CNTR_EN
      if (lb_addr == LB_ADDR_W'(8)) lb_rd_data_d = LB_DATA_W'(stall_q);
`endif
    end
  end

`ifdef SYS_MEM_WARB_PERF_CNTR_EN
  always_comb begin
    gcnt_d  = gcnt_q;
    stall_d = stall_q;
    if (lb_wr_en && lb_addr == LB_ADDR_W'(8)) begin
      gcnt_d  = '{default: '0};
      stall_d = '0;
    end else begin
      if (accept && gcnt_q[gnt_id] != '1) gcnt_d[gnt_id] = gcnt_q[gnt_id] + 32'd1;
      if (out_vld_q && cntrlr.cntrlr_wait && stall_q != '1) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_q  <= '{default: '0};
      stall_q <= '0;
    end else begin
      gcnt_q  <= gcnt_d;
      stall_q <= stall_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_en_q     <= 1'b1;
      weight_q     <= '{default: WEIGHT_W'(DEFAULT_WEIGHT)};
      credit_q     <= '{default: WEIGHT_W'(DEFAULT_WEIGHT)};
      offset_q     <= '{default: '0};
      rr_ptr_q     <= '0;
      out_vld_q    <= 1'b0;
      out_wr_q     <= 1'b0;
      out_addr_q   <= '0;
      out_wdata_q  <= '0;
      out_id_q     <= '0;
      tag_mem_q    <= '{default: '0};
      tag_wptr_q   <= '0;
      tag_rptr_q   <= '0;
      tag_cnt_q    <= '0;
      rd_vld_q     <= '0;
      rdata_q      <= '0;
      flags_q      <= '0;
      lb_wr_vld_q  <= 1'b0;
      lb_rd_vld_q  <= 1'b0;
      lb_rd_data_q <= '0;
    end else begin
      arb_en_q     <= arb_en_d;
      weight_q     <= weight_d;
      credit_q     <= credit_d;
      offset_q     <= offset_d;
      rr_ptr_q     <= rr_ptr_d;
      out_vld_q    <= out_vld_d;
      out_wr_q     <= out_wr_d;
      out_addr_q   <= out_addr_d;
      out_wdata_q  <= out_wdata_d;
      out_id_q     <= out_id_d;
      tag_mem_q    <= tag_mem_d;
      tag_wptr_q   <= tag_wptr_d;
      tag_rptr_q   <= tag_rptr_d;
      tag_cnt_q    <= tag_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rdata_q      <= rdata_d;
      flags_q      <= flags_d;
      lb_wr_vld_q  <= lb_wr_en;
      lb_rd_vld_q  <= lb_rd_en;
      lb_rd_data_q <= lb_rd_data_d;
    end
  end

  assign lb_wr_valid         = lb_wr_vld_q;
  assign lb_rd_valid         = lb_rd_vld_q;
  assign lb_rd_data          = lb_rd_data_q;
  assign agent_rd_valid      = rd_vld_q;
  assign agent_rdata         = {NUM_AGENTS{rdata_q}};
  assign cntrlr.cntrlr_wren  = out_vld_q & out_wr_q;
  assign cntrlr.cntrlr_rden  = out_vld_q & ~out_wr_q;
  assign cntrlr.cntrlr_addr  = out_addr_q;
  assign cntrlr.cntrlr_wdata = out_wdata_q;
endmodule
